// File: rtl/ahb_req_pkg.sv
// Shared AHB requester types: htrans encodings, FSM states, beat size and 1 KB page mask.
package ahb_req_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_LAST
    } state_t;

    localparam logic [31:0] BEAT_BYTES = 32'd4;
    localparam logic [9:0]  KB_MASK    = 10'h3FF;

    // A burst may not continue SEQ across a 1 KB page, so a page start forces NONSEQ.
    function automatic logic is_kb_start(input logic [31:0] addr);
        return (addr[9:0] & KB_MASK) == 10'h000;
    endfunction

endpackage

// File: rtl/ahb_req_wait_timer.sv
// Grant-wait counter: synchronous clear, enable, saturates at 16'hFFFF, flags the MAX_WAIT step.
module ahb_req_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] cnt,
    output logic        hit_next
);

    localparam logic [16:0] LIMIT = 17'(MAX_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    // High when the increment taken this cycle makes the count reach MAX_WAIT.
    assign hit_next = (({1'b0, cnt} + 17'd1) >= LIMIT);

endmodule

// File: rtl/ahb_bus_requester.sv
// AHB bus master requester: arbitrates for the bus and issues 1..16 beat INCR bursts.
// Optional locked transfers are enabled by defining AHB_REQ_LOCK_EN.
module ahb_bus_requester
    import ahb_req_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_len,
`ifdef AHB_REQ_LOCK_EN
    input  logic        cmd_lock,
    output logic        hlock,
`endif
    output logic        hbusreq,
    input  logic        hgrant,
    input  logic        hready,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic        done,
    output logic        timeout,
    output logic [15:0] wait_cnt
);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic        write_q;
    logic [3:0]  rem_q;
    logic        first_q;
    logic        lock_q;

    logic        handshake;
    logic        own;
    logic        grant_lost;
    logic        lock_err;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_hit;

    assign handshake  = (state == ST_IDLE) && cmd_valid;
    assign own        = hgrant && hready;
    // Grant withdrawn while a non-final beat is accepted: that beat completes, the rest wait for re-grant.
    assign grant_lost = (state == ST_XFER) && hready && !hgrant && (rem_q != 4'd0);
    assign lock_err   = grant_lost && lock_q;
    assign tmr_clr    = handshake || (grant_lost && !lock_err);
    assign tmr_en     = (state == ST_REQ) && !own;

    ahb_req_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .cnt      (wait_cnt),
        .hit_next (tmr_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (own)          state_next = ST_XFER;
                else if (tmr_hit) state_next = ST_IDLE;
            end
            ST_XFER: begin
                if (hready) begin
                    if (rem_q == 4'd0) state_next = ST_LAST;
                    else if (lock_err) state_next = ST_IDLE;
                    else if (!hgrant)  state_next = ST_REQ;
                end
            end
            ST_LAST: begin
                if (hready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            rem_q   <= '0;
            first_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr & ~32'h3;
                        write_q <= cmd_write;
                        rem_q   <= cmd_len;
                        first_q <= 1'b1;
`ifdef AHB_REQ_LOCK_EN
                        lock_q  <= cmd_lock;
`else
                        lock_q  <= 1'b0;
`endif
                    end
                end
                ST_XFER: begin
                    if (hready) begin
                        addr_q  <= addr_q + BEAT_BYTES;
                        first_q <= !hgrant;
                        if (rem_q != 4'd0) rem_q <= rem_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        hbusreq   = 1'b0;
        htrans    = HTRANS_IDLE;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_REQ: begin
                hbusreq = 1'b1;
                timeout = !own && tmr_hit;
            end
            ST_XFER: begin
                hbusreq = (rem_q != 4'd0);
                htrans  = (first_q || is_kb_start(addr_q)) ? HTRANS_NONSEQ : HTRANS_SEQ;
                timeout = lock_err;
            end
            ST_LAST: done = hready;
            default: ;
        endcase
    end

    assign haddr  = addr_q;
    assign hwrite = write_q;
`ifdef AHB_REQ_LOCK_EN
    assign hlock  = lock_q && hbusreq;
`endif

endmodule

// File: tb/tb_ahb_bus_requester.sv
// Directed bench for ahb_bus_requester: per-cycle vector table plus timeout and mid-burst reset sequences.
module tb_ahb_bus_requester;

    localparam logic       H  = 1'b1;
    localparam logic       L  = 1'b0;
    localparam logic [1:0] TI = 2'b00;
    localparam logic [1:0] TN = 2'b10;
    localparam logic [1:0] TS = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [3:0]  cmd_len;
    logic        hbusreq;
    logic        hgrant;
    logic        hready;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic        done;
    logic        timeout;
    logic [15:0] wait_cnt;

    int checks = 0;
    int errors = 0;

    ahb_bus_requester #(
        .MAX_WAIT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_len   (cmd_len),
        .hbusreq   (hbusreq),
        .hgrant    (hgrant),
        .hready    (hready),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .done      (done),
        .timeout   (timeout),
        .wait_cnt  (wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic        cw;
        logic [3:0]  cl;
        logic        gnt;
        logic        rdy;
        logic        e_ready;
        logic        e_busreq;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic        e_done;
        logic [15:0] e_wait;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic cv, input logic [31:0] ca, input logic cw,
                               input logic [3:0] cl, input logic gnt, input logic rdy,
                               input logic er, input logic eb, input logic [1:0] et,
                               input logic [31:0] ea, input logic ew, input logic ed,
                               input logic [15:0] ewc);
        vec_t r;
        r.cv = cv; r.ca = ca; r.cw = cw; r.cl = cl; r.gnt = gnt; r.rdy = rdy;
        r.e_ready = er; r.e_busreq = eb; r.e_trans = et; r.e_addr = ea;
        r.e_write = ew; r.e_done = ed; r.e_wait = ewc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, " hbusreq"},   32'(hbusreq),   32'd0);
        chk({tag, " htrans"},    32'(htrans),    32'd0);
        chk({tag, " haddr"},     haddr,          32'd0);
        chk({tag, " hwrite"},    32'(hwrite),    32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
        chk({tag, " timeout"},   32'(timeout),   32'd0);
        chk({tag, " wait_cnt"},  32'(wait_cnt),  32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = L; cmd_addr = '0; cmd_write = L; cmd_len = '0;
        hgrant = L; hready = H;

        // Grant three cycles after request; a command offered mid-burst is ignored.
        tbl.push_back(v(H, 32'h100, H, 4'd3, L, H, H, L, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(H, 32'hDEAD0000, L, 4'd15, L, H, L, H, TI, 32'h0, L, L, 16'd1));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TI, 32'h0, L, L, 16'd2));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h100, H, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TS, 32'h104, H, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TS, 32'h108, H, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TS, 32'h10C, H, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TI, 32'h0, L, H, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, H, L, TI, 32'h0, L, L, 16'd3));
        // Wait states on beat 2.
        tbl.push_back(v(H, 32'h100, H, 4'd3, H, H, H, L, TI, 32'h0, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h100, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, L, L, H, TS, 32'h104, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, L, L, H, TS, 32'h104, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TS, 32'h104, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TS, 32'h108, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TS, 32'h10C, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TI, 32'h0, L, H, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, H, L, TI, 32'h0, L, L, 16'd0));
        // Grant removed while beat 1 is issued, regranted four cycles later.
        tbl.push_back(v(H, 32'h100, L, 4'd3, H, H, H, L, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h100, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TS, 32'h104, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TI, 32'h0, L, L, 16'd1));
        tbl.push_back(v(L, 32'h0, L, 4'd0, L, H, L, H, TI, 32'h0, L, L, 16'd2));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h108, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TS, 32'h10C, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, L, L, L, TI, 32'h0, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TI, 32'h0, L, H, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, H, L, TI, 32'h0, L, L, 16'd3));
        // 1 KB crossing from an unaligned start address.
        tbl.push_back(v(H, 32'h3FA, H, 4'd3, H, H, H, L, TI, 32'h0, L, L, 16'd3));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h3F8, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TS, 32'h3FC, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TN, 32'h400, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TS, 32'h404, H, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TI, 32'h0, L, H, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, H, L, TI, 32'h0, L, L, 16'd0));
        // Single-beat burst.
        tbl.push_back(v(H, 32'h20, L, 4'd0, H, H, H, L, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, H, TI, 32'h0, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TN, 32'h20, L, L, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, L, L, TI, 32'h0, L, H, 16'd0));
        tbl.push_back(v(L, 32'h0, L, 4'd0, H, H, H, L, TI, 32'h0, L, L, 16'd0));

        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid = tbl[i].cv; cmd_addr = tbl[i].ca; cmd_write = tbl[i].cw;
            cmd_len = tbl[i].cl; hgrant = tbl[i].gnt; hready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("r%0d cmd_ready", i), 32'(cmd_ready), 32'(tbl[i].e_ready));
            chk($sformatf("r%0d hbusreq", i),   32'(hbusreq),   32'(tbl[i].e_busreq));
            chk($sformatf("r%0d htrans", i),    32'(htrans),    32'(tbl[i].e_trans));
            chk($sformatf("r%0d done", i),      32'(done),      32'(tbl[i].e_done));
            chk($sformatf("r%0d timeout", i),   32'(timeout),   32'd0);
            chk($sformatf("r%0d wait_cnt", i),  32'(wait_cnt),  32'(tbl[i].e_wait));
            if (tbl[i].e_trans != TI) begin
                chk($sformatf("r%0d haddr", i),  haddr,        tbl[i].e_addr);
                chk($sformatf("r%0d hwrite", i), 32'(hwrite),  32'(tbl[i].e_write));
            end
            @(posedge clk); #1;
        end

        // Timeout with MAX_WAIT=8 and no grant.
        cmd_valid = H; cmd_addr = 32'h40; cmd_write = H; cmd_len = 4'd1; hgrant = L; hready = H;
        @(negedge clk);
        chk("tmo handshake", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = L;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo c%0d timeout", k),  32'(timeout),  (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("tmo c%0d hbusreq", k),  32'(hbusreq),  32'd1);
            chk($sformatf("tmo c%0d wait_cnt", k), 32'(wait_cnt), 32'(k - 1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo after timeout",   32'(timeout),   32'd0);
        chk("tmo after hbusreq",   32'(hbusreq),   32'd0);
        chk("tmo after cmd_ready", 32'(cmd_ready), 32'd1);
        chk("tmo after wait_cnt",  32'(wait_cnt),  32'd8);
        chk("tmo after htrans",    32'(htrans),    32'd0);
        @(posedge clk); #1;

        // Reset asserted while beat 2 is on the bus.
        cmd_valid = H; cmd_addr = 32'h100; cmd_write = H; cmd_len = 4'd3; hgrant = H; hready = H;
        @(posedge clk); #1;
        cmd_valid = L;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid beat2 htrans", 32'(htrans), 32'(TS));
        chk("mid beat2 haddr",  haddr,       32'h104);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid async");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("mid hold%0d done", k), 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid released done", 32'(done), 32'd0);

        cmd_valid = H; cmd_addr = 32'h80; cmd_write = L; cmd_len = 4'd0; hgrant = H; hready = H;
        @(negedge clk);
        chk("fresh handshake", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = L;
        @(negedge clk);
        chk("fresh req hbusreq",  32'(hbusreq),  32'd1);
        chk("fresh req wait_cnt", 32'(wait_cnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh htrans", 32'(htrans), 32'(TN));
        chk("fresh haddr",  haddr,       32'h80);
        chk("fresh hwrite", 32'(hwrite), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh done", 32'(done), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fresh idle cmd_ready", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
